// File: rtl/rs_alu_pkg.sv
// rs_alu_pkg: reservation-station entry type, sizing constants and the ROB flush-range helper
// shared by the ALU RS and other consumers of rob tags.
package rs_alu_pkg;
    localparam int RS_ALU_DEPTH = 8;
    localparam int N_WAKE       = 3;
    localparam int PREG_W       = 7;
    localparam int ROB_DEPTH    = 16;
    localparam int ROB_TAG_W    = 5;
    localparam int CNT_W        = $clog2(RS_ALU_DEPTH) + 1;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
        OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_ADDI
    } alu_op_e;

    typedef struct packed {
        alu_op_e               op;
        logic [PREG_W-1:0]     pd;
        logic [PREG_W-1:0]     ps1;
        logic                  ps1_rdy;
        logic [PREG_W-1:0]     ps2;
        logic                  ps2_rdy;
        logic [ROB_TAG_W-1:0]  rob_index;
        logic [15:0]           imm;
    } rs_data;

    // true when tag lies in the circular range mp_tag+1 .. tail-1 (empty when mp_tag+1 == tail)
    function automatic logic rob_in_flush_range(input logic [ROB_TAG_W-1:0] tag,
                                                input logic [ROB_TAG_W-1:0] mp_tag,
                                                input logic [ROB_TAG_W-1:0] tail);
        logic [ROB_TAG_W-1:0] d, n;
        d = (tag - mp_tag - ROB_TAG_W'(1)) % ROB_TAG_W'(ROB_DEPTH);
        n = (tail - mp_tag - ROB_TAG_W'(1)) % ROB_TAG_W'(ROB_DEPTH);
        return d < n;
    endfunction
endpackage

// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch, wakeup, issue and flush signals of the ALU reservation station.
interface rs_alu_if;
    import rs_alu_pkg::*;
    logic                              disp_valid;
    rs_data                            disp_data;
    logic                              disp_ready;
    logic [N_WAKE-1:0]                 wake_valid;
    logic [N_WAKE-1:0][PREG_W-1:0]     wake_tag;
    logic                              fu_alu_ready;
    logic                              issued;
    rs_data                            data_out;
    logic                              mispredict;
    logic [ROB_TAG_W-1:0]              mispredict_tag;
    logic [ROB_TAG_W-1:0]              curr_rob_tag;
    logic [CNT_W-1:0]                  count;

    modport master (
        output disp_valid, disp_data, wake_valid, wake_tag, fu_alu_ready,
               mispredict, mispredict_tag, curr_rob_tag,
        input  disp_ready, issued, data_out, count
    );
    modport slave (
        input  disp_valid, disp_data, wake_valid, wake_tag, fu_alu_ready,
               mispredict, mispredict_tag, curr_rob_tag,
        output disp_ready, issued, data_out, count
    );
endinterface

// File: rtl/rs_alu_select.sv
// rs_alu_select: one-hot grant over ready entries; oldest-first (ties to lowest index) when
// RS_ALU_AGE_SELECT_EN is defined, otherwise lowest index wins.
module rs_alu_select import rs_alu_pkg::*; (
    input  logic [RS_ALU_DEPTH-1:0]            ready,
`ifdef RS_ALU_AGE_SELECT_EN
    input  logic [RS_ALU_DEPTH-1:0][CNT_W-1:0] age,
`endif
    output logic [RS_ALU_DEPTH-1:0]            grant,
    output logic                               grant_valid
);
    assign grant_valid = |ready;
`ifdef RS_ALU_AGE_SELECT_EN
    logic [CNT_W-1:0] best;
    // scanning downward with >= lets the lowest index win among equal ages
    always_comb begin
        best = '0;
        grant = '0;
        for (int i = RS_ALU_DEPTH - 1; i >= 0; i--)
            if (ready[i] && age[i] >= best) begin
                best = age[i];
                grant = '0;
                grant[i] = 1'b1;
            end
    end
`else
    assign grant = ready & (~ready + RS_ALU_DEPTH'(1));
`endif
endmodule

// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station -- dispatch, tag wakeup, single issue, mispredict flush.
// Define RS_ALU_AGE_SELECT_EN for oldest-first issue; default is lowest-index-first.
module rs_alu import rs_alu_pkg::*; (
    input logic     clk,
    input logic     reset,
    rs_alu_if.slave rs
);
    logic [RS_ALU_DEPTH-1:0] valid, ready, flush, grant, disp_sel;
    logic                    grant_valid, do_disp, do_issue;
    logic [CNT_W-1:0]        cnt;
    rs_data                  entry [RS_ALU_DEPTH];
    rs_data                  entry_nxt [RS_ALU_DEPTH];
    rs_data                  issue_data;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < RS_ALU_DEPTH; i++) cnt += CNT_W'(valid[i]);
    end

    assign rs.count      = cnt;
    assign rs.disp_ready = cnt != CNT_W'(RS_ALU_DEPTH);
    // lowest clear bit of valid is the slot a dispatch fills
    assign disp_sel      = ~valid & (valid + RS_ALU_DEPTH'(1));
    assign do_disp       = rs.disp_valid && rs.disp_ready && !rs.mispredict;
    assign do_issue      = rs.fu_alu_ready && grant_valid && !rs.mispredict;

    always_comb begin
        ready = '0;
        flush = '0;
        issue_data = '0;
        entry_nxt = entry;
        for (int i = 0; i < RS_ALU_DEPTH; i++) begin
            ready[i] = valid[i] && entry[i].ps1_rdy && entry[i].ps2_rdy;
            flush[i] = rs.mispredict && rob_in_flush_range(entry[i].rob_index, rs.mispredict_tag, rs.curr_rob_tag);
            issue_data = grant[i] ? entry[i] : issue_data;
            entry_nxt[i] = do_disp && disp_sel[i] ? rs.disp_data : entry[i];
            // x0 is always ready; wakeup also covers the entry written at this edge
            entry_nxt[i].ps1_rdy |= entry_nxt[i].ps1 == '0;
            entry_nxt[i].ps2_rdy |= entry_nxt[i].ps2 == '0;
            for (int w = 0; w < N_WAKE; w++) begin
                entry_nxt[i].ps1_rdy |= rs.wake_valid[w] && rs.wake_tag[w] == entry_nxt[i].ps1;
                entry_nxt[i].ps2_rdy |= rs.wake_valid[w] && rs.wake_tag[w] == entry_nxt[i].ps2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            entry <= '{default: '0};
            rs.issued <= 1'b0;
            rs.data_out <= '0;
        end else begin
            valid <= (valid & ~flush & ~({RS_ALU_DEPTH{do_issue}} & grant)) | ({RS_ALU_DEPTH{do_disp}} & disp_sel);
            entry <= entry_nxt;
            rs.issued <= do_issue;
            if (do_issue) rs.data_out <= issue_data;
        end
    end

`ifdef RS_ALU_AGE_SELECT_EN
    logic [RS_ALU_DEPTH-1:0][CNT_W-1:0] age;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) age <= '0;
        else for (int i = 0; i < RS_ALU_DEPTH; i++)
            age[i] <= do_disp && disp_sel[i] ? '0 : age[i] + CNT_W'(valid[i] && age[i] != '1);
    end
    rs_alu_select u_sel (.ready(ready), .age(age), .grant(grant), .grant_valid(grant_valid));
`else
    rs_alu_select u_sel (.ready(ready), .grant(grant), .grant_valid(grant_valid));
`endif
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed bench for rs_alu with a slot-level behavioural model checked every cycle.
module tb_rs_alu;
    import rs_alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    rs_alu_if bus();
    rs_alu dut (.clk(clk), .reset(reset), .rs(bus));
    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;

    typedef struct {bit v; rs_data d; int t;} slot_t;
    slot_t  m [RS_ALU_DEPTH];
    bit     exp_issued = 1'b0;
    rs_data exp_data = '0;
    int     edge_no = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int mcount();
        int n = 0;
        foreach (m[i]) n += int'(m[i].v);
        return n;
    endfunction

    function automatic bit in_flush(int tag, int mp, int tail);
        for (int t = (mp + 1) % ROB_DEPTH; t != tail % ROB_DEPTH; t = (t + 1) % ROB_DEPTH)
            if (t == tag) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit woke(logic [PREG_W-1:0] tag);
        if (tag == 0) return 1'b1;
        for (int w = 0; w < N_WAKE; w++)
            if (bus.wake_valid[w] && bus.wake_tag[w] == tag) return 1'b1;
        return 1'b0;
    endfunction

    function automatic rs_data mk(alu_op_e op, int pd, int ps1, bit r1, int ps2, bit r2, int rob);
        rs_data e;
        e.op = op;
        e.pd = PREG_W'(pd);
        e.ps1 = PREG_W'(ps1);
        e.ps1_rdy = r1;
        e.ps2 = PREG_W'(ps2);
        e.ps2_rdy = r2;
        e.rob_index = ROB_TAG_W'(rob);
        e.imm = 16'(pd * 7 + rob);
        return e;
    endfunction

    // model: what the station holds and issues, from the behavioural rules
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (m[i]) m[i].v = 1'b0;
            exp_issued = 1'b0;
            exp_data = '0;
            edge_no = 0;
        end else begin
            int pick, slot, n, best, age;
            pick = -1; slot = -1; n = 0; best = -1;
            for (int i = 0; i < RS_ALU_DEPTH; i++) begin
                if (m[i].v) n++;
                else if (slot < 0) slot = i;
                if (m[i].v && m[i].d.ps1_rdy && m[i].d.ps2_rdy) begin
                    age = edge_no - m[i].t - 1;
                    if (age > 15) age = 15;
`ifdef RS_ALU_AGE_SELECT_EN
                    if (age > best) begin best = age; pick = i; end
`else
                    if (pick < 0) pick = i;
`endif
                end
            end
            exp_issued = bus.fu_alu_ready && pick >= 0 && !bus.mispredict;
            if (exp_issued) begin exp_data = m[pick].d; m[pick].v = 1'b0; end
            if (bus.mispredict)
                foreach (m[i])
                    if (m[i].v && in_flush(int'(m[i].d.rob_index), int'(bus.mispredict_tag), int'(bus.curr_rob_tag)))
                        m[i].v = 1'b0;
            if (bus.disp_valid && n < RS_ALU_DEPTH && !bus.mispredict) begin
                m[slot].v = 1'b1;
                m[slot].d = bus.disp_data;
                m[slot].t = edge_no;
            end
            foreach (m[i]) begin
                if (woke(m[i].d.ps1)) m[i].d.ps1_rdy = 1'b1;
                if (woke(m[i].d.ps2)) m[i].d.ps2_rdy = 1'b1;
            end
            edge_no++;
        end
    end

    always @(negedge clk) begin
        check("issued", 64'(bus.issued), 64'(exp_issued));
        check("data_out", 64'(bus.data_out), 64'(exp_data));
        check("count", 64'(bus.count), 64'(mcount()));
        check("disp_ready", 64'(bus.disp_ready), 64'(mcount() != RS_ALU_DEPTH));
    end

    task automatic disp(rs_data e);
        bus.disp_valid = 1'b1;
        bus.disp_data = e;
        @(negedge clk);
        bus.disp_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.disp_valid = 1'b0;
        bus.disp_data = '0;
        bus.wake_valid = '0;
        bus.wake_tag = '0;
        bus.fu_alu_ready = 1'b0;
        bus.mispredict = 1'b0;
        bus.mispredict_tag = '0;
        bus.curr_rob_tag = ROB_TAG_W'(3);
        #1 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_count", 64'(bus.count), 64'(0));
        check("rst_disp_ready", 64'(bus.disp_ready), 64'(1));

        // async reset in the middle of operation
        for (int i = 0; i < 3; i++) disp(mk(OP_ADD, 30 + i, 40 + i, 1'b0, 0, 1'b0, i));
        check("t1_count3", 64'(bus.count), 64'(3));
        #2 reset = 1'b0;
        #1;
        check("t1_async_count", 64'(bus.count), 64'(0));
        check("t1_async_ready", 64'(bus.disp_ready), 64'(1));
        check("t1_async_issued", 64'(bus.issued), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // ADDI with both operands ready issues two edges after dispatch
        bus.fu_alu_ready = 1'b1;
        disp(mk(OP_ADDI, 5, 0, 1'b1, 0, 1'b1, 1));
        check("t2_not_yet", 64'(bus.issued), 64'(0));
        @(negedge clk);
        check("t2_issued", 64'(bus.issued), 64'(1));
        check("t2_pd", 64'(bus.data_out.pd), 64'(5));
        check("t2_count", 64'(bus.count), 64'(0));

        // same-cycle wake on port 1 is not lost
        bus.wake_valid[1] = 1'b1;
        bus.wake_tag[1] = PREG_W'(12);
        disp(mk(OP_SUB, 6, 3, 1'b1, 12, 1'b0, 2));
        bus.wake_valid = '0;
        @(negedge clk);
        check("t3_issued", 64'(bus.issued), 64'(1));
        check("t3_op", 64'(bus.data_out.op), 64'(OP_SUB));
        check("t3_ps2_rdy", 64'(bus.data_out.ps2_rdy), 64'(1));
        disp(mk(OP_SUB, 7, 3, 1'b1, 13, 1'b0, 3));
        repeat (4) @(negedge clk);
        check("t3_never_issued", 64'(bus.issued), 64'(0));
        check("t3_still_held", 64'(bus.count), 64'(1));
        pulse_reset();

        // fill, drop when full, wake one and free a slot
        for (int i = 0; i < RS_ALU_DEPTH; i++) disp(mk(OP_ADD, 8 + i, 20 + i, 1'b0, 0, 1'b0, i));
        check("t4_full_count", 64'(bus.count), 64'(8));
        check("t4_full_ready", 64'(bus.disp_ready), 64'(0));
        disp(mk(OP_ADD, 99, 0, 1'b1, 0, 1'b1, 9));
        check("t4_dropped", 64'(bus.count), 64'(8));
        bus.wake_valid[0] = 1'b1;
        bus.wake_tag[0] = PREG_W'(23);
        @(negedge clk);
        bus.wake_valid = '0;
        check("t4_wake_edge_ready", 64'(bus.disp_ready), 64'(0));
        @(negedge clk);
        check("t4_issued_pd", 64'(bus.data_out.pd), 64'(11));
        check("t4_count7", 64'(bus.count), 64'(7));
        check("t4_ready_again", 64'(bus.disp_ready), 64'(1));
        pulse_reset();

        // mispredict: keep rob 14/15, flush 0/2, no issue that edge
        bus.fu_alu_ready = 1'b0;
        disp(mk(OP_AND, 40, 0, 1'b0, 0, 1'b0, 14));
        disp(mk(OP_OR, 41, 50, 1'b0, 0, 1'b0, 15));
        disp(mk(OP_XOR, 42, 51, 1'b0, 0, 1'b0, 0));
        disp(mk(OP_SLL, 43, 52, 1'b0, 0, 1'b0, 2));
        bus.fu_alu_ready = 1'b1;
        bus.mispredict = 1'b1;
        bus.mispredict_tag = ROB_TAG_W'(15);
        bus.curr_rob_tag = ROB_TAG_W'(3);
        @(negedge clk);
        bus.mispredict = 1'b0;
        check("t5_no_issue", 64'(bus.issued), 64'(0));
        check("t5_count2", 64'(bus.count), 64'(2));
        @(negedge clk);
        check("t5_rob14", 64'(bus.data_out.rob_index), 64'(14));
        bus.wake_valid[2] = 1'b1;
        bus.wake_tag[2] = PREG_W'(50);
        @(negedge clk);
        bus.wake_valid = '0;
        @(negedge clk);
        check("t5_rob15", 64'(bus.data_out.rob_index), 64'(15));
        check("t5_empty", 64'(bus.count), 64'(0));
        bus.wake_valid = 3'b011;
        bus.wake_tag[0] = PREG_W'(51);
        bus.wake_tag[1] = PREG_W'(52);
        @(negedge clk);
        bus.wake_valid = '0;
        repeat (3) @(negedge clk);
        check("t5_flushed_gone", 64'(bus.issued), 64'(0));
        pulse_reset();

        // older slot 3 vs newer slot 0
        bus.fu_alu_ready = 1'b0;
        disp(mk(OP_ADD, 1, 0, 1'b1, 0, 1'b1, 4));
        disp(mk(OP_ADD, 2, 60, 1'b0, 0, 1'b1, 5));
        disp(mk(OP_ADD, 3, 61, 1'b0, 0, 1'b1, 6));
        disp(mk(OP_ADD, 4, 0, 1'b1, 0, 1'b1, 7));
        bus.fu_alu_ready = 1'b1;
        @(negedge clk);
        bus.fu_alu_ready = 1'b0;
        check("t6_first_pd", 64'(bus.data_out.pd), 64'(1));
        disp(mk(OP_ADD, 5, 0, 1'b1, 0, 1'b1, 8));
        bus.fu_alu_ready = 1'b1;
        @(negedge clk);
`ifdef RS_ALU_AGE_SELECT_EN
        check("t6_pick_old", 64'(bus.data_out.pd), 64'(4));
        @(negedge clk);
        check("t6_pick_new", 64'(bus.data_out.pd), 64'(5));
`else
        check("t6_pick_low", 64'(bus.data_out.pd), 64'(5));
        @(negedge clk);
        check("t6_pick_next", 64'(bus.data_out.pd), 64'(4));
`endif
        bus.fu_alu_ready = 1'b0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
